// File: rtl/class_select_menu.sv
// Character-class selection menu overlay: N class slots, a preview slot and a CONFIRM button.
// Mouse clicks drive a small NONE/SEL/LOCKED FSM; a two-stage pixel pipeline composites slot
// sprites, hover/select frames, the preview and the button over the incoming VGA stream.
// Sprite pixels come from an external synchronous ROM, read one cycle after the request.
// Where the preview overlaps a slot, the preview owns the sprite fetch for that pixel.
module class_select_menu #(
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned SLOT_W      = 39,
  parameter int unsigned SLOT_H      = 53,
  parameter int unsigned SLOT_X0     = 256,
  parameter int unsigned SLOT_PITCH  = 128,
  parameter int unsigned SLOT_Y      = 512,
  parameter int unsigned PREVIEW_X   = 492,
  parameter int unsigned PREVIEW_Y   = 538,
  parameter int unsigned BTN_X       = 387,
  parameter int unsigned BTN_Y       = 240,
  parameter int unsigned BTN_W       = 250,
  parameter int unsigned BTN_H       = 75,
  parameter logic [4*NUM_CLASSES-1:0] CLASS_HP    = {4'd3, 4'd5, 4'd10},
  parameter logic [4*NUM_CLASSES-1:0] CLASS_AGGRO = {4'd2, 4'd1, 4'd3},
  parameter logic [11:0] TRANSPARENT = 12'hF00,
  parameter logic [11:0] HOVER_RGB   = 12'hFF0,
  parameter logic [11:0] SEL_RGB     = 12'h0F0,
  parameter logic [11:0] BTN_RGB     = 12'h08F
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_game_active,
  input  logic [11:0] i_mouse_x,
  input  logic [11:0] i_mouse_y,
  input  logic        i_mouse_clicked,
  output logic [2:0]  o_sprite_id,
  output logic [12:0] o_sprite_addr,
  input  logic [11:0] i_sprite_rgb,
  output logic [2:0]  o_char_class,
  output logic [3:0]  o_char_hp,
  output logic [3:0]  o_class_aggro,
  output logic        o_class_locked,
  input  logic [11:0] i_vga_hcount,
  input  logic [11:0] i_vga_vcount,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  input  logic        i_vga_hblank,
  input  logic        i_vga_vblank,
  input  logic [11:0] i_vga_rgb,
  output logic [11:0] o_vga_hcount,
  output logic [11:0] o_vga_vcount,
  output logic        o_vga_hsync,
  output logic        o_vga_vsync,
  output logic        o_vga_hblank,
  output logic        o_vga_vblank,
  output logic [11:0] o_vga_rgb
);

  localparam logic [12:0] SlotW  = 13'(SLOT_W);
  localparam logic [12:0] SlotH  = 13'(SLOT_H);
  localparam logic [12:0] SlotY  = 13'(SLOT_Y);
  localparam logic [12:0] PrevX  = 13'(PREVIEW_X);
  localparam logic [12:0] PrevY  = 13'(PREVIEW_Y);
  localparam logic [12:0] BtnX   = 13'(BTN_X);
  localparam logic [12:0] BtnY   = 13'(BTN_Y);
  localparam logic [12:0] BtnW   = 13'(BTN_W);
  localparam logic [12:0] BtnH   = 13'(BTN_H);
  localparam logic [11:0] FrameWhite = 12'hFFF;

  typedef enum logic [1:0] {StNone, StSel, StLocked} state_e;

  // Half-open interval test: v in [lo, lo+len).
  function automatic logic in_span(input logic [12:0] v, input logic [12:0] lo,
                                   input logic [12:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

  function automatic logic [12:0] slot_x(input logic [2:0] idx);
    return 13'(SLOT_X0 + 32'(idx) * SLOT_PITCH);
  endfunction

  // Outer 2px ring of a slot-sized box.
  function automatic logic on_ring(input logic [12:0] col, input logic [12:0] row);
    return (col < 13'd2) || (col >= SlotW - 13'd2) || (row < 13'd2) || (row >= SlotH - 13'd2);
  endfunction

  state_e      r_state, w_state_next;
  logic [2:0]  r_sel_idx, w_sel_next;
  logic        r_click_prev;
  logic        w_click;
  logic [2:0]  w_class_d;
  logic [3:0]  w_hp_d, w_aggro_d;
  logic        w_locked_d;
  logic [2:0]  r_char_class;
  logic [3:0]  r_char_hp, r_class_aggro;
  logic        r_class_locked;

  logic [12:0] w_mx, w_my, w_hc, w_vc;
  logic        w_hover_hit, w_mouse_btn;
  logic [2:0]  w_hover_idx;
  logic        w_slot_hit, w_slot_ring, w_prev_hit, w_prev_ring, w_btn_hit;
  logic [2:0]  w_slot_idx;
  logic [12:0] w_slot_col, w_slot_row, w_prev_col, w_prev_row;
  logic [2:0]  w_req_id;
  logic [12:0] w_req_addr;

  // Stage 1 registers
  logic [11:0] r1_hc, r1_vc, r1_rgb;
  logic        r1_hs, r1_vs, r1_hb, r1_vb;
  logic        r1_draw, r1_sel_frame, r1_hover_frame, r1_prev_ring, r1_prev_none, r1_spr_en;
  logic        r1_btn;
  logic [2:0]  r1_sprite_id;
  logic [12:0] r1_sprite_addr;
  // Stage 2 registers
  logic [11:0] r2_hc, r2_vc, r2_rgb;
  logic        r2_hs, r2_vs, r2_hb, r2_vb;
  logic        r2_draw, r2_sel_frame, r2_hover_frame, r2_prev_ring, r2_prev_none, r2_spr_en;
  logic        r2_btn;
  logic        w_spr_opaque;
  logic [11:0] w_rgb;

  assign w_mx    = {1'b0, i_mouse_x};
  assign w_my    = {1'b0, i_mouse_y};
  assign w_hc    = {1'b0, i_vga_hcount};
  assign w_vc    = {1'b0, i_vga_vcount};
  assign w_click = i_mouse_clicked & ~r_click_prev;
  assign w_mouse_btn = in_span(w_mx, BtnX, BtnW) && in_span(w_my, BtnY, BtnH);

  // Which slot (if any) the mouse is over.
  always_comb begin
    w_hover_hit = 1'b0;
    w_hover_idx = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (in_span(w_mx, slot_x(3'(i)), SlotW) && in_span(w_my, SlotY, SlotH)) begin
        w_hover_hit = 1'b1;
        w_hover_idx = 3'(i);
      end
    end
  end

  // Which slot (if any) the current pixel falls in.
  always_comb begin
    w_slot_hit = 1'b0;
    w_slot_idx = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (in_span(w_hc, slot_x(3'(i)), SlotW) && in_span(w_vc, SlotY, SlotH)) begin
        w_slot_hit = 1'b1;
        w_slot_idx = 3'(i);
      end
    end
  end

  assign w_slot_col  = w_hc - slot_x(w_slot_idx);
  assign w_slot_row  = w_vc - SlotY;
  assign w_slot_ring = on_ring(w_slot_col, w_slot_row);
  assign w_prev_hit  = in_span(w_hc, PrevX, SlotW) && in_span(w_vc, PrevY, SlotH);
  assign w_prev_col  = w_hc - PrevX;
  assign w_prev_row  = w_vc - PrevY;
  assign w_prev_ring = on_ring(w_prev_col, w_prev_row);
  assign w_btn_hit   = in_span(w_hc, BtnX, BtnW) && in_span(w_vc, BtnY, BtnH);

  // Sprite request: preview shows the selected class and wins the fetch over a slot.
  always_comb begin
    w_req_id   = '0;
    w_req_addr = '0;
    if (w_prev_hit) begin
      w_req_id   = r_sel_idx;
      w_req_addr = w_prev_row * SlotW + w_prev_col;
    end else if (w_slot_hit) begin
      w_req_id   = w_slot_idx;
      w_req_addr = w_slot_row * SlotW + w_slot_col;
    end
  end

  // FSM state register and click edge detector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StNone;
      r_sel_idx    <= '0;
      r_click_prev <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sel_idx    <= w_sel_next;
      r_click_prev <= i_mouse_clicked;
    end
  end

  // FSM next-state: game start outranks a same-cycle click while selecting.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel_idx;
    unique case (r_state)
      StNone: begin
        if (w_click && w_hover_hit && (i_game_active == 2'd0)) begin
          w_state_next = StSel;
          w_sel_next   = w_hover_idx;
        end
      end
      StSel: begin
        if (i_game_active != 2'd0) begin
          w_state_next = StLocked;
        end else if (w_click && w_mouse_btn) begin
          w_state_next = StLocked;
        end else if (w_click && w_hover_hit) begin
          w_sel_next = w_hover_idx;
        end
      end
      StLocked: ;
      default: w_state_next = StNone;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    w_class_d  = '0;
    w_hp_d     = '0;
    w_aggro_d  = '0;
    w_locked_d = (r_state == StLocked);
    if (r_state != StNone) begin
      w_class_d = r_sel_idx + 3'd1;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (r_sel_idx == 3'(i)) begin
          w_hp_d    = CLASS_HP[4*i +: 4];
          w_aggro_d = CLASS_AGGRO[4*i +: 4];
        end
      end
    end
  end

  // Registered character outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_char_class   <= '0;
      r_char_hp      <= '0;
      r_class_aggro  <= '0;
      r_class_locked <= 1'b0;
    end else begin
      r_char_class   <= w_class_d;
      r_char_hp      <= w_hp_d;
      r_class_aggro  <= w_aggro_d;
      r_class_locked <= w_locked_d;
    end
  end

  // Stage 1: capture timing, hit-test flags and issue the sprite ROM request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {r1_hc, r1_vc, r1_rgb, r1_hs, r1_vs, r1_hb, r1_vb} <= '0;
      {r1_draw, r1_sel_frame, r1_hover_frame, r1_prev_ring, r1_prev_none, r1_spr_en} <= '0;
      r1_btn         <= 1'b0;
      r1_sprite_id   <= '0;
      r1_sprite_addr <= '0;
    end else begin
      r1_hc          <= i_vga_hcount;
      r1_vc          <= i_vga_vcount;
      r1_rgb         <= i_vga_rgb;
      r1_hs          <= i_vga_hsync;
      r1_vs          <= i_vga_vsync;
      r1_hb          <= i_vga_hblank;
      r1_vb          <= i_vga_vblank;
      r1_draw        <= (i_game_active == 2'd0) && (r_state != StLocked);
      r1_sel_frame   <= w_slot_hit && w_slot_ring && (r_state == StSel) &&
                        (w_slot_idx == r_sel_idx);
      r1_hover_frame <= w_slot_hit && w_slot_ring && w_hover_hit && (w_hover_idx == w_slot_idx);
      r1_prev_ring   <= w_prev_hit && w_prev_ring;
      r1_prev_none   <= (r_state == StNone);
      r1_spr_en      <= w_prev_hit ? (r_state == StSel) : w_slot_hit;
      r1_btn         <= w_btn_hit && (r_state == StSel);
      r1_sprite_id   <= w_req_id;
      r1_sprite_addr <= w_req_addr;
    end
  end

  // Stage 2: align flags with the ROM data that arrives one cycle after the request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      {r2_hc, r2_vc, r2_rgb, r2_hs, r2_vs, r2_hb, r2_vb} <= '0;
      {r2_draw, r2_sel_frame, r2_hover_frame, r2_prev_ring, r2_prev_none, r2_spr_en} <= '0;
      r2_btn <= 1'b0;
    end else begin
      {r2_hc, r2_vc, r2_rgb, r2_hs, r2_vs, r2_hb, r2_vb} <=
        {r1_hc, r1_vc, r1_rgb, r1_hs, r1_vs, r1_hb, r1_vb};
      {r2_draw, r2_sel_frame, r2_hover_frame, r2_prev_ring, r2_prev_none, r2_spr_en} <=
        {r1_draw, r1_sel_frame, r1_hover_frame, r1_prev_ring, r1_prev_none, r1_spr_en};
      r2_btn <= r1_btn;
    end
  end

  assign w_spr_opaque = (i_sprite_rgb != TRANSPARENT);

  // Final compositing, highest priority first.
  always_comb begin
    w_rgb = r2_rgb;
    if (!r2_draw) begin
      w_rgb = r2_rgb;
    end else if (r2_sel_frame) begin
      w_rgb = SEL_RGB;
    end else if (r2_hover_frame) begin
      w_rgb = HOVER_RGB;
    end else if (r2_prev_ring && (r2_prev_none || !w_spr_opaque)) begin
      w_rgb = FrameWhite;
    end else if (r2_spr_en && w_spr_opaque) begin
      w_rgb = i_sprite_rgb;
    end else if (r2_btn) begin
      w_rgb = BTN_RGB;
    end
  end

  assign o_sprite_id    = r1_sprite_id;
  assign o_sprite_addr  = r1_sprite_addr;
  assign o_char_class   = r_char_class;
  assign o_char_hp      = r_char_hp;
  assign o_class_aggro  = r_class_aggro;
  assign o_class_locked = r_class_locked;
  assign o_vga_hcount   = r2_hc;
  assign o_vga_vcount   = r2_vc;
  assign o_vga_hsync    = r2_hs;
  assign o_vga_vsync    = r2_vs;
  assign o_vga_hblank   = r2_hb;
  assign o_vga_vblank   = r2_vb;
  assign o_vga_rgb      = w_rgb;

endmodule
